sync_fifo: RTL
==============

Name: sync_fifo

Overview:
Single-clock synchronous FIFO that buffers a data stream ahead of the register, pipeline and counter stages in the sequential block set. The producer pushes words with wr_en, and the downstream stage pops them with rd_en. Occupancy is tracked with an up/down counter. Read data is registered, and the read latency is one cycle.

Parameters:
WIDTH, 8, data word width in bits (>= 1)
DEPTH, 4, number of entries; power of two, >= 2
AW, $clog2(DEPTH), pointer width; localparam, not overridable

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous reset, active-high
wr_en  input  1  push request
wr_data  input  WIDTH  word to push
rd_en  input  1  pop request
rd_data  output  WIDTH  popped word, registered
rd_valid  output  1  high for exactly one cycle when rd_data carries a newly popped word
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  AW+1  current occupancy, 0..DEPTH
overflow  output  1  sticky error flag (see Optional Feature)
underflow  output  1  sticky error flag (see Optional Feature)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates occur on posedge clk.
- Reset (rst=1 at a posedge) has priority over all other inputs in that cycle:
  - wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
  - Storage array contents are not reset.
  - Reset mid-operation discards all stored words. Any wr_en/rd_en in the reset cycle is ignored.
- Outputs after reset: empty=1, full=0.
- Accept rules, evaluated from state before the edge:
  - wr_acc = wr_en && !full
  - rd_acc = rd_en && !empty
- On wr_acc: mem[wr_ptr] <= wr_data; wr_ptr increments and wraps DEPTH-1 -> 0 (natural AW-bit wrap).
- On rd_acc: rd_data <= mem[rd_ptr]; rd_ptr increments and wraps; rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data holds its last value.
- Count update:
  - wr_acc only: +1
  - rd_acc only: -1
  - both or neither: unchanged
- Count never leaves the range 0..DEPTH.
- full and empty are combinational decodes of count. They are never both high.
- Simultaneous wr_en and rd_en:
  - When empty: the write is accepted and the read is rejected. There is no read-through; the word becomes readable next cycle.
  - When full: the read is accepted and the write is rejected. A full FIFO cannot accept a write in the same cycle as a pop.
  - Otherwise: both are accepted and count is unchanged.
- Ordering: strict FIFO. A word written in cycle N is readable by an rd_en at earliest in cycle N+1, with rd_data valid in cycle N+2.
- Rejected requests have no effect on pointers, count or storage.
- No combinational path exists from wr_en or rd_en to any output except via registers. full, empty and count depend only on registers.

Optional Feature:
Macro: SYNC_FIFO_ERR_FLAGS_EN
- Defined:
  - overflow is set at the posedge where wr_en && full.
  - underflow is set at the posedge where rd_en && empty.
  - Both flags are sticky; only rst clears them.
  - Setting a flag does not alter data-path behaviour.
- Not defined:
  - overflow and underflow are tied to constant 0.
  - No flag registers are synthesized.
  - The ports remain present so instantiations are identical in both builds.

Test Plan:
- Reset then idle (WIDTH=8, DEPTH=4): rst=1 for 2 cycles, release -> empty=1, full=0, count=0, rd_valid=0, rd_data=8'h00.
- Fill and drain:
  - Push 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles -> count 1,2,3,4, full=1 after 4th.
  - Then rd_en for 4 cycles -> rd_data 11,22,33,44, each one cycle after its rd_en with rd_valid=1; empty=1 at end.
- Wrap-around: push 3, pop 3, then push 8'h55..8'h58 (4 words, pointers wrap) -> pops return 55,56,57,58 in order, count returns to 0.
- Boundary simultaneous ops:
  - When empty, wr_en=rd_en=1 with 8'hA5 -> count=1, rd_valid=0 next cycle.
  - When full, wr_en=rd_en=1 with 8'hEE -> oldest word is popped, count=3, 8'hEE never appears.
  - At count=2, both asserted -> count stays 2, order preserved.
- Reset mid-operation: with count=3, assert rst for one cycle while wr_en=rd_en=1 -> count=0, empty=1, rd_valid=0; a subsequent pop attempt yields no rd_valid.
- Error flags:
  - With SYNC_FIFO_ERR_FLAGS_EN: rd_en on empty -> underflow=1 and stays 1; fill to 4 and wr_en -> overflow=1; rst clears both.
  - Without the macro: same stimulus -> both flags remain 0.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO with up/down occupancy counter and registered read data (1-cycle read latency).
// Overflow/underflow sticky flags exist only when SYNC_FIFO_ERR_FLAGS_EN is defined; otherwise tied low.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             wr_acc, rd_acc;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign count    = count_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  // Acceptance is judged from pre-edge occupancy, so empty blocks the read and full blocks the write.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage is deliberately not reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q || (wr_en && full);
    unf_d = unf_q || (rd_en && empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
